// File: rtl/lock_phase_counter_pkg.sv
// Shared definitions for the lock phase sequencer: phase encoding, count
// width, blank-digit value and default phase lengths.
package lock_phase_counter_pkg;

  localparam int CNT_W = 10;

  typedef logic [CNT_W-1:0] count_t;
  typedef logic [2:0]       phase_t;

  // Phase encoding as seen on the phase output and by the display stage.
  localparam phase_t PH_IDLE      = 3'd0;
  localparam phase_t PH_ARRIVE    = 3'd1;
  localparam phase_t PH_FANDP     = 3'd2;
  localparam phase_t PH_WAIT_EVAC = 3'd3;
  localparam phase_t PH_EVACUATE  = 3'd4;

  // Value parked on countEvacuate outside EVACUATE; decodes to a blank digit.
  localparam int DEF_EVAC_IDLE_VAL = 8;

  // Default phase lengths in ticks.
  localparam int DEF_ARRIVE_SECS = 5;
  localparam int DEF_FANDP_SECS  = 8;
  localparam int DEF_EVAC_SECS   = 8;

  // A phase of N ticks starts its countdown at N-1 and leaves on the tick
  // that finds the count already at zero.
  function automatic count_t secs_to_load(input int secs);
    return count_t'(secs - 1);
  endfunction

endpackage

// File: rtl/phase_down_counter.sv
// Load / decrement-on-enable down counter with a zero flag. Clear returns
// the counter to its parked value, which is also its reset value.
module phase_down_counter
  import lock_phase_counter_pkg::*;
#(
  parameter count_t IDLE_VAL = '0
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clr_i,
  input  logic   load_i,
  input  count_t load_val_i,
  input  logic   dec_i,
  output count_t count_o,
  output logic   zero_o
);

  count_t count_q, count_d;

  // Next count: clear beats load beats decrement; never wraps below zero.
  always_comb begin
    // NOTE: default assignment first so no path leaves count_d unassigned,
    // which would otherwise infer a latch.
    count_d = count_q;
    if (clr_i) begin
      count_d = IDLE_VAL;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_d = count_q - count_t'(1);
    end
  end

  // Count register, parked at IDLE_VAL while reset is low.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignment so every register samples pre-edge values.
    if (!rst_n) count_q <= IDLE_VAL;
    else        count_q <= count_d;
  end

  assign count_o = count_q;
  assign zero_o  = (count_q == '0);

endmodule

// File: rtl/lock_phase_counter.sv
// Lock phase sequencer/timer feeding the 7-segment decode stage.
// Walks IDLE -> ARRIVE -> FANDP -> WAIT_EVAC -> EVACUATE -> IDLE, counting
// each timed phase down on the 1 Hz tick. All outputs are registered.
// Optional build macro LOCK_ABORT_EN adds an abort input that returns any
// active phase to IDLE with counts restored to their reset values.
module lock_phase_counter
  import lock_phase_counter_pkg::*;
#(
  parameter int ARRIVE_SECS   = DEF_ARRIVE_SECS,
  parameter int FANDP_SECS    = DEF_FANDP_SECS,
  parameter int EVAC_SECS     = DEF_EVAC_SECS,
  parameter int EVAC_IDLE_VAL = DEF_EVAC_IDLE_VAL
) (
  input  logic         Clock,
  input  logic         Reset,
  input  logic         tick,
  input  logic         arrive_req,
  input  logic         evac_req,
`ifdef LOCK_ABORT_EN
  input  logic         abort,
`endif
  output logic [9:0]   countArrive,
  output logic [9:0]   countFandP,
  output logic [9:0]   countEvacuate,
  output logic [2:0]   phase,
  output logic         busy,
  output logic         evac_done
);

  phase_t state_q, state_d;
  logic   busy_q, done_q, done_d;
  logic   abort_hit;

  logic a_clr, a_load, a_dec, a_zero;
  logic f_clr, f_load, f_dec, f_zero;
  logic e_clr, e_load, e_dec, e_zero;

`ifdef LOCK_ABORT_EN
  assign abort_hit = abort && (state_q != PH_IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  // Phase transitions and counter control; abort outranks tick and requests.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    a_clr = 1'b0; a_load = 1'b0; a_dec = 1'b0;
    f_clr = 1'b0; f_load = 1'b0; f_dec = 1'b0;
    e_clr = 1'b0; e_load = 1'b0; e_dec = 1'b0;

    if (abort_hit) begin
      state_d = PH_IDLE;
      a_clr   = 1'b1;
      f_clr   = 1'b1;
      e_clr   = 1'b1;
    end else begin
      case (state_q)
        PH_IDLE: begin
          // A tick on the entry edge is not counted: only the load happens.
          if (arrive_req) begin
            state_d = PH_ARRIVE;
            a_load  = 1'b1;
          end
        end
        PH_ARRIVE: begin
          if (tick) begin
            if (a_zero) begin
              state_d = PH_FANDP;
              a_clr   = 1'b1;
              f_load  = 1'b1;
            end else begin
              a_dec = 1'b1;
            end
          end
        end
        PH_FANDP: begin
          if (tick) begin
            if (f_zero) state_d = PH_WAIT_EVAC;
            else        f_dec   = 1'b1;
          end
        end
        PH_WAIT_EVAC: begin
          if (evac_req) begin
            state_d = PH_EVACUATE;
            e_load  = 1'b1;
          end
        end
        PH_EVACUATE: begin
          if (tick) begin
            if (e_zero) begin
              state_d = PH_IDLE;
              e_clr   = 1'b1;
              done_d  = 1'b1;
            end else begin
              e_dec = 1'b1;
            end
          end
        end
        default: begin
          // Unused encodings recover to IDLE with counts parked.
          state_d = PH_IDLE;
          a_clr   = 1'b1;
          f_clr   = 1'b1;
          e_clr   = 1'b1;
        end
      endcase
    end
  end

  // Phase register plus registered busy and evac_done flags.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= PH_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != PH_IDLE);
      done_q  <= done_d;
    end
  end

  phase_down_counter #(.IDLE_VAL('0)) u_arrive (
    .clk        (Clock),
    .rst_n      (Reset),
    .clr_i      (a_clr),
    .load_i     (a_load),
    .load_val_i (secs_to_load(ARRIVE_SECS)),
    .dec_i      (a_dec),
    .count_o    (countArrive),
    .zero_o     (a_zero)
  );

  phase_down_counter #(.IDLE_VAL('0)) u_fandp (
    .clk        (Clock),
    .rst_n      (Reset),
    .clr_i      (f_clr),
    .load_i     (f_load),
    .load_val_i (secs_to_load(FANDP_SECS)),
    .dec_i      (f_dec),
    .count_o    (countFandP),
    .zero_o     (f_zero)
  );

  phase_down_counter #(.IDLE_VAL(count_t'(EVAC_IDLE_VAL))) u_evac (
    .clk        (Clock),
    .rst_n      (Reset),
    .clr_i      (e_clr),
    .load_i     (e_load),
    .load_val_i (secs_to_load(EVAC_SECS)),
    .dec_i      (e_dec),
    .count_o    (countEvacuate),
    .zero_o     (e_zero)
  );

  assign phase     = state_q;
  assign busy      = busy_q;
  assign evac_done = done_q;

endmodule

// File: tb/tb_lock_phase_counter.sv
// Directed bench for lock_phase_counter: a vector table covering a full
// arrive/fill/wait/evacuate cycle, then hand-written corner sequences.
module tb_lock_phase_counter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       arrive_req = 1'b0;
  logic       evac_req = 1'b0;
`ifdef LOCK_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic [9:0] count_arrive, count_fandp, count_evac;
  logic [2:0] phase;
  logic       busy, evac_done;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic       tick;
    logic       arr;
    logic       evac;
    logic [2:0] ph;
    logic [9:0] ca;
    logic [9:0] cf;
    logic [9:0] ce;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  lock_phase_counter dut (
    .Clock         (clk),
    .Reset         (rst_n),
    .tick          (tick),
    .arrive_req    (arrive_req),
    .evac_req      (evac_req),
`ifdef LOCK_ABORT_EN
    .abort         (abort),
`endif
    .countArrive   (count_arrive),
    .countFandP    (count_fandp),
    .countEvacuate (count_evac),
    .phase         (phase),
    .busy          (busy),
    .evac_done     (evac_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] ph, input logic [9:0] ca,
                           input logic [9:0] cf, input logic [9:0] ce,
                           input logic b, input logic d);
    check({tag, ".phase"},     32'(phase),        32'(ph));
    check({tag, ".cntArrive"}, 32'(count_arrive), 32'(ca));
    check({tag, ".cntFandP"},  32'(count_fandp),  32'(cf));
    check({tag, ".cntEvac"},   32'(count_evac),   32'(ce));
    check({tag, ".busy"},      32'(busy),         32'(b));
    check({tag, ".evac_done"}, 32'(evac_done),    32'(d));
  endtask

  task automatic add(input logic t, input logic a, input logic e, input logic [2:0] ph,
                     input int ca, input int cf, input int ce, input logic b, input logic d);
    vec_t v;
    v.tick = t; v.arr = a; v.evac = e; v.ph = ph;
    v.ca = 10'(ca); v.cf = 10'(cf); v.ce = 10'(ce); v.busy = b; v.done = d;
    vecs.push_back(v);
  endtask

  // Drive inputs on the falling edge, sample 1 time unit after the rising edge.
  task automatic step(input logic t, input logic a, input logic e);
    @(negedge clk);
    tick = t; arrive_req = a; evac_req = e;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 3'd0, 10'd0, 10'd0, 10'd8, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full cycle with default lengths.
    add(1, 0, 0, 0, 0, 0, 8, 0, 0);                       // tick ignored in IDLE
    add(0, 0, 1, 0, 0, 0, 8, 0, 0);                       // evac_req ignored in IDLE
    add(0, 1, 0, 1, 4, 0, 8, 1, 0);                       // enter ARRIVE
    for (int i = 3; i >= 0; i--) add(1, 0, 0, 1, i, 0, 8, 1, 0);
    add(0, 0, 0, 1, 0, 0, 8, 1, 0);                       // hold without tick
    add(1, 0, 0, 2, 0, 7, 8, 1, 0);                       // 5th tick -> FANDP
    for (int i = 6; i >= 0; i--) add(1, 0, 0, 2, 0, i, 8, 1, 0);
    add(1, 0, 0, 3, 0, 0, 8, 1, 0);                       // 8th tick -> WAIT_EVAC
    for (int i = 0; i < 10; i++) add(1, 0, 0, 3, 0, 0, 8, 1, 0);
    add(1, 1, 0, 3, 0, 0, 8, 1, 0);                       // arrive_req dropped
    add(0, 0, 1, 4, 0, 0, 7, 1, 0);                       // enter EVACUATE
    for (int i = 6; i >= 0; i--) add(1, 0, 0, 4, 0, 0, i, 1, 0);
    add(1, 1, 0, 0, 0, 0, 8, 0, 1);                       // final tick; arrive dropped
    add(0, 0, 0, 0, 0, 0, 8, 0, 0);                       // done is one cycle, still IDLE

    foreach (vecs[i]) begin
      step(vecs[i].tick, vecs[i].arr, vecs[i].evac);
      check_all($sformatf("vec%0d", i), vecs[i].ph, vecs[i].ca, vecs[i].cf,
                vecs[i].ce, vecs[i].busy, vecs[i].done);
    end

    // Asynchronous reset mid-FANDP with countFandP = 3.
    step(0, 1, 0);
    repeat (5) step(1, 0, 0);
    repeat (4) step(1, 0, 0);
    check_all("pre_rst", 3'd2, 10'd0, 10'd3, 10'd8, 1'b1, 1'b0);
    @(negedge clk);
    tick = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_all("async_rst", 3'd0, 10'd0, 10'd0, 10'd8, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1, 0, 0);
    check_all("post_rst", 3'd0, 10'd0, 10'd0, 10'd8, 1'b0, 1'b0);

    // Both requests plus tick in IDLE: arrive taken, no decrement.
    step(1, 1, 1);
    check_all("both_req", 3'd1, 10'd4, 10'd0, 10'd8, 1'b1, 1'b0);
    step(0, 0, 1);
    check_all("evac_in_arrive", 3'd1, 10'd4, 10'd0, 10'd8, 1'b1, 1'b0);
    step(1, 0, 1);
    check_all("evac_tick_arrive", 3'd1, 10'd3, 10'd0, 10'd8, 1'b1, 1'b0);

`ifdef LOCK_ABORT_EN
    // Abort during EVACUATE at countEvacuate = 5.
    repeat (4) step(1, 0, 0);                             // -> FANDP, cf=7
    repeat (8) step(1, 0, 0);                             // -> WAIT_EVAC
    step(0, 0, 1);                                        // -> EVACUATE, ce=7
    repeat (2) step(1, 0, 0);
    check_all("pre_abort", 3'd4, 10'd0, 10'd0, 10'd5, 1'b1, 1'b0);
    abort = 1'b1;
    step(1, 0, 0);
    check_all("abort_evac", 3'd0, 10'd0, 10'd0, 10'd8, 1'b0, 1'b0);
    step(0, 1, 0);                                        // abort ignored in IDLE
    check_all("abort_idle", 3'd1, 10'd4, 10'd0, 10'd8, 1'b1, 1'b0);
    step(1, 0, 0);
    check_all("abort_arrive", 3'd0, 10'd0, 10'd0, 10'd8, 1'b0, 1'b0);
    abort = 1'b0;
`endif

    @(negedge clk);
    tick = 1'b0; arrive_req = 1'b0; evac_req = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
